gpr_file: RTL and testbench

Parametrised general-purpose register file for the tiny16 datapath, successor to the fixed 8×16 file. It adds configurable width and depth, a write port addressed independently of the read selects, write-first read bypass, and dedicated PC-increment and SP push/pop update channels. All updates happen on the rising edge. The block sits between instruction decode, which drives the selects and enables, and the ALU/memory path, which consumes `src`/`dst` and returns `in`.

---
 rtl/gpr_file_if.sv | 28 ++
 rtl/gpr_file.sv | 72 +++++++
 tb/tb_gpr_file.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gpr_file_if.sv
// Register-file access bus between decode (master) and the register file (slave).
interface gpr_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] src_sel;
  logic [ADDR_W-1:0] dst_sel;
  logic              out_en;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] dst;
  logic              in_en;
  logic [ADDR_W-1:0] wr_sel;
  logic [DATA_W-1:0] in;
  logic              pc_inc;
  logic [1:0]        sp_op;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] sp;

  modport master (
    output src_sel, dst_sel, out_en, in_en, wr_sel, in, pc_inc, sp_op,
    input  src, dst, pc, sp
  );

  modport slave (
    input  src_sel, dst_sel, out_en, in_en, wr_sel, in, pc_inc, sp_op,
    output src, dst, pc, sp
  );
endinterface

// File: rtl/gpr_file.sv
// Parametrised GPR file: r0 doubles as PC, r1 as SP. Two registered,
// write-first read ports, one write port, PC-increment and SP push/pop.
module gpr_file #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 3,
  parameter int                 PC_STEP = 1,
  parameter logic [DATA_W-1:0]  RST_PC  = '0,
  parameter logic [DATA_W-1:0]  RST_SP  = '1
) (
  input  logic       clk,
  input  logic       rst,
  gpr_file_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  // Registers are kept in flops, not block RAM: every entry may change in the
  // same edge and r0/r1 are observed continuously on pc/sp.
  logic [DATA_W-1:0] regs_reg  [DEPTH];
  logic [DATA_W-1:0] regs_next [DEPTH];
  logic [DATA_W-1:0] src_reg;
  logic [DATA_W-1:0] dst_reg;

  // Next value for every register; the explicit write is applied last so it
  // overrides the PC/SP update channels when it targets r0 or r1.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_next[i] = regs_reg[i];
    end
    if (bus.pc_inc) begin
      regs_next[0] = regs_reg[0] + DATA_W'(PC_STEP);
    end
    case (bus.sp_op)
      2'b01:   regs_next[1] = regs_reg[1] - DATA_W'(1);
      2'b10:   regs_next[1] = regs_reg[1] + DATA_W'(1);
      default: regs_next[1] = regs_reg[1];
    endcase
    if (bus.in_en) begin
      regs_next[bus.wr_sel] = bus.in;
    end
  end

  // Register state update; reset discards any same-cycle write or op.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 0)      regs_reg[i] <= RST_PC;
        else if (i == 1) regs_reg[i] <= RST_SP;
        else             regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= regs_next[i];
      end
    end
  end

  // Read ports sample the post-update value so a same-edge write is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg <= '0;
      dst_reg <= '0;
    end else if (bus.out_en) begin
      src_reg <= regs_next[bus.src_sel];
      dst_reg <= regs_next[bus.dst_sel];
    end
  end

  assign bus.src = src_reg;
  assign bus.dst = dst_reg;
  assign bus.pc  = regs_reg[0];
  assign bus.sp  = regs_reg[1];
endmodule

// File: tb/tb_gpr_file.sv
// Scoreboard bench for gpr_file: three instances (16x8 with PC reset 0,
// 16x8 with PC reset FFFE, 32x16) share one stimulus stream; a reference
// model predicts each edge's outputs and a monitor compares them.
module tb_gpr_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  s_src = '0, s_dst = '0, s_wr = '0;
  logic [31:0] s_in = '0;
  logic        s_oe = 1'b0, s_ie = 1'b0, s_pi = 1'b0;
  logic [1:0]  s_so = '0;

  gpr_file_if #(.DATA_W(16), .ADDR_W(3)) bus0 ();
  gpr_file_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();
  gpr_file_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

  assign bus0.src_sel = s_src[2:0]; assign bus1.src_sel = s_src[2:0]; assign bus2.src_sel = s_src;
  assign bus0.dst_sel = s_dst[2:0]; assign bus1.dst_sel = s_dst[2:0]; assign bus2.dst_sel = s_dst;
  assign bus0.wr_sel  = s_wr[2:0];  assign bus1.wr_sel  = s_wr[2:0];  assign bus2.wr_sel  = s_wr;
  assign bus0.in      = s_in[15:0]; assign bus1.in      = s_in[15:0]; assign bus2.in      = s_in;
  assign bus0.out_en = s_oe; assign bus1.out_en = s_oe; assign bus2.out_en = s_oe;
  assign bus0.in_en  = s_ie; assign bus1.in_en  = s_ie; assign bus2.in_en  = s_ie;
  assign bus0.pc_inc = s_pi; assign bus1.pc_inc = s_pi; assign bus2.pc_inc = s_pi;
  assign bus0.sp_op  = s_so; assign bus1.sp_op  = s_so; assign bus2.sp_op  = s_so;

  gpr_file #(.DATA_W(16), .ADDR_W(3)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  gpr_file #(.DATA_W(16), .ADDR_W(3), .RST_PC(16'hFFFE)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  gpr_file #(.DATA_W(32), .ADDR_W(4)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct packed {
    logic            chk;
    logic [2:0][31:0] src;
    logic [2:0][31:0] dst;
    logic [2:0][31:0] pc;
    logic [2:0][31:0] sp;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [3][16];
  logic [31:0] m_src [3];
  logic [31:0] m_dst [3];
  bit          known = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [31:0] mask_of(int k);
    return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Reference model: one edge of the register file, straight from the rules.
  task automatic model_edge();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      int depth;
      logic [31:0] msk;
      logic [31:0] nxt [16];
      depth = (k == 2) ? 16 : 8;
      msk = mask_of(k);
      if (rst) begin
        for (int j = 0; j < 16; j++) m_regs[k][j] = 32'h0;
        m_regs[k][0] = (k == 1) ? 32'h0000_FFFE : 32'h0;
        m_regs[k][1] = msk;
        m_src[k] = 32'h0;
        m_dst[k] = 32'h0;
      end else begin
        for (int j = 0; j < 16; j++) nxt[j] = m_regs[k][j];
        if (s_pi) nxt[0] = (m_regs[k][0] + 32'd1) & msk;
        if (s_so == 2'b01) nxt[1] = (m_regs[k][1] - 32'd1) & msk;
        if (s_so == 2'b10) nxt[1] = (m_regs[k][1] + 32'd1) & msk;
        if (s_ie) nxt[int'(s_wr) % depth] = s_in & msk;
        if (s_oe) begin
          m_src[k] = nxt[int'(s_src) % depth];
          m_dst[k] = nxt[int'(s_dst) % depth];
        end
        for (int j = 0; j < 16; j++) m_regs[k][j] = nxt[j];
      end
      e.src[k] = m_src[k];
      e.dst[k] = m_dst[k];
      e.pc[k]  = m_regs[k][0];
      e.sp[k]  = m_regs[k][1];
    end
    if (rst) known = 1'b1;
    e.chk = known;
    exp_q.push_back(e);
  endtask

  // Drive one edge's inputs away from the rising edge and record the prediction.
  task automatic step(input bit r, input bit ie, input logic [3:0] wr, input logic [31:0] din,
                      input bit oe, input logic [3:0] ss, input logic [3:0] ds,
                      input bit pi, input logic [1:0] so);
    @(negedge clk);
    rst = r; s_ie = ie; s_wr = wr; s_in = din; s_oe = oe;
    s_src = ss; s_dst = ds; s_pi = pi; s_so = so;
    model_edge();
  endtask

  task automatic cmp(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL inst%0d %s: got %h expected %h", k, name, got, want);
  endtask

  // Monitor: after every rising edge, pop one prediction and compare all outputs.
  initial begin
    exp_t e;
    logic [2:0][31:0] a_src, a_dst, a_pc, a_sp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a_src = {bus2.src, 16'h0, bus1.src, 16'h0, bus0.src};
        a_dst = {bus2.dst, 16'h0, bus1.dst, 16'h0, bus0.dst};
        a_pc  = {bus2.pc,  16'h0, bus1.pc,  16'h0, bus0.pc};
        a_sp  = {bus2.sp,  16'h0, bus1.sp,  16'h0, bus0.sp};
        if (e.chk) begin
          for (int k = 0; k < 3; k++) begin
            cmp("src", k, a_src[k], e.src[k]);
            cmp("dst", k, a_dst[k], e.dst[k]);
            cmp("pc",  k, a_pc[k],  e.pc[k]);
            cmp("sp",  k, a_sp[k],  e.sp[k]);
          end
          $display("edge: src0=%h dst0=%h pc0=%h sp0=%h pc1=%h src2=%h sp2=%h",
                   bus0.src, bus0.dst, bus0.pc, bus0.sp, bus1.pc, bus2.src, bus2.sp);
        end
      end
    end
  end

  initial begin
    // Reset with pending write, pc_inc and push all discarded.
    step(1, 1, 4'd2, 32'h1111_2222, 1, 4'd2, 4'd3, 1, 2'b01);
    for (int i = 2; i < 16; i += 2) step(0, 0, 4'd0, 32'h0, 1, 4'(i), 4'(i + 1), 0, 2'b00);
    // Write-first bypass, then hold with out_en low.
    step(0, 1, 4'd3, 32'h0000_A5A5, 1, 4'd3, 4'd2, 0, 2'b00);
    step(0, 1, 4'd3, 32'h0000_5A5A, 0, 4'd2, 4'd2, 0, 2'b00);
    // PC step and wrap (instance 1 starts at FFFE), then write beats pc_inc.
    repeat (3) step(0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 1, 2'b00);
    step(0, 1, 4'd0, 32'h0000_1234, 1, 4'd0, 4'd1, 1, 2'b00);
    // SP pop/push wrap, joint push+pc_inc, sp_op=11 no-op.
    step(1, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 2'b00);
    step(0, 0, 4'd0, 32'h0, 1, 4'd1, 4'd0, 0, 2'b10);
    step(0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 2'b01);
    step(0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 2'b01);
    step(0, 0, 4'd0, 32'h0, 1, 4'd0, 4'd1, 1, 2'b01);
    step(0, 0, 4'd0, 32'h0, 1, 4'd0, 4'd1, 0, 2'b11);
    // Reset mid-stream, then write 0042 to r4 and read it back.
    for (int i = 0; i < 5; i++)
      step(0, 1, 4'($urandom_range(2, 15)), $urandom, 1, 4'($urandom), 4'($urandom), 1, 2'b10);
    step(1, 1, 4'd5, 32'h0000_7777, 1, 4'd5, 4'd4, 1, 2'b01);
    step(0, 1, 4'd4, 32'h0000_0042, 1, 4'd4, 4'd0, 0, 2'b00);
    step(0, 0, 4'd0, 32'h0, 1, 4'd1, 4'd4, 0, 2'b00);
    // Wide instance: r15 = DEADBEEF, then pop from all ones.
    step(0, 1, 4'd15, 32'hDEAD_BEEF, 0, 4'd0, 4'd0, 0, 2'b00);
    step(0, 0, 4'd0, 32'h0, 1, 4'd15, 4'd7, 0, 2'b00);
    step(1, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 2'b00);
    step(0, 0, 4'd0, 32'h0, 1, 4'd1, 4'd15, 0, 2'b10);
    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), $urandom, 1'($urandom),
           4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
    step(0, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
